// File: rtl/upg_pkg.sv
// Shared constants and types for the UART program loader.
package upg_pkg;

   localparam logic [7:0]  CMD_IMEM  = 8'h00;
   localparam logic [7:0]  CMD_DMEM  = 8'h01;
   localparam logic [7:0]  CMD_END   = 8'hFF;

   localparam int unsigned MAX_WORDS = 16384;
   localparam int unsigned WIDX_W    = 14;
   localparam int unsigned ADR_W     = 15;
   localparam int unsigned DAT_W     = 32;
   localparam int unsigned LEN_W     = 16;

   localparam logic [2:0]  ST_OFF    = 3'd0;
   localparam logic [2:0]  ST_CMD    = 3'd1;
   localparam logic [2:0]  ST_LEN0   = 3'd2;
   localparam logic [2:0]  ST_LEN1   = 3'd3;
   localparam logic [2:0]  ST_DATA   = 3'd4;
   localparam logic [2:0]  ST_DONE   = 3'd5;
   localparam logic [2:0]  ST_ERR    = 3'd6;

   typedef enum logic [2:0] {
      S_OFF  = ST_OFF,
      S_CMD  = ST_CMD,
      S_LEN0 = ST_LEN0,
      S_LEN1 = ST_LEN1,
      S_DATA = ST_DATA,
      S_DONE = ST_DONE,
      S_ERR  = ST_ERR
   } state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: synchroniser, start-bit validation, mid-bit sampling.
module uart_rx_core
   import upg_pkg::*;
#(
   parameter int unsigned CLK_HZ = 10_000_000,
   parameter int unsigned BAUD   = 128_000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       i_rx,
   output logic       o_byte_vld,
   output logic [7:0] o_byte,
   output logic       o_frm_err
);

   localparam int unsigned DIV   = CLK_HZ / BAUD;
   localparam int unsigned HALF  = DIV / 2;
   localparam int unsigned CNT_W = $clog2(DIV);

   rx_state_t          r_st;
   logic [1:0]         r_sync;
   logic               r_prev;
   logic [CNT_W-1:0]   r_cnt;
   logic [2:0]         r_bit;
   logic [7:0]         r_sh;
   logic               w_rx;

   assign w_rx = r_sync[1];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_st       <= RX_IDLE;
         r_sync     <= 2'b11;
         r_prev     <= 1'b1;
         r_cnt      <= '0;
         r_bit      <= '0;
         r_sh       <= '0;
         o_byte_vld <= 1'b0;
         o_byte     <= '0;
         o_frm_err  <= 1'b0;
      end else begin
         r_sync     <= {r_sync[0], i_rx};
         r_prev     <= w_rx;
         o_byte_vld <= 1'b0;
         o_frm_err  <= 1'b0;
         case (r_st)
            RX_IDLE: begin
               if (r_prev && !w_rx) begin
                  r_st  <= RX_START;
                  r_cnt <= '0;
               end
            end
            // Line must still be low half a bit later, otherwise it was a glitch.
            RX_START: begin
               if (r_cnt == CNT_W'(HALF - 1)) begin
                  r_cnt <= '0;
                  r_bit <= '0;
                  r_st  <= w_rx ? RX_IDLE : RX_DATA;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            RX_DATA: begin
               if (r_cnt == CNT_W'(DIV - 1)) begin
                  r_cnt <= '0;
                  r_sh  <= {w_rx, r_sh[7:1]};
                  if (r_bit == 3'd7) r_st <= RX_STOP;
                  else               r_bit <= r_bit + 3'd1;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            RX_STOP: begin
               if (r_cnt == CNT_W'(DIV - 1)) begin
                  r_cnt <= '0;
                  r_st  <= RX_IDLE;
                  if (w_rx) begin
                     o_byte_vld <= 1'b1;
                     o_byte     <= r_sh;
                  end else begin
                     o_frm_err  <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: r_st <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/upg_loader.sv
// UART program loader: parses CMD/LEN/DATA frames and drives the upg_* write port.
module upg_loader
   import upg_pkg::*;
#(
   parameter int unsigned CLK_HZ      = 10_000_000,
   parameter int unsigned BAUD        = 128_000,
   parameter int unsigned TIMEOUT_CYC = 2_000_000
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             rx,
   output logic             upg_wen_o,
   output logic [ADR_W-1:0] upg_adr_o,
   output logic [DAT_W-1:0] upg_dat_o,
   output logic             upg_done_o,
   output logic             busy,
   output logic             err
);

   localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

   logic              w_byte_vld;
   logic [7:0]        w_byte;
   logic              w_frm_err;
   logic              w_timed;
   logic              w_timeout;
   logic [LEN_W-1:0]  w_len;
   logic [DAT_W-1:0]  w_word;

   state_t            r_state;
   logic              r_target;
   logic [LEN_W-1:0]  r_len;
   logic [WIDX_W-1:0] r_widx;
   logic [1:0]        r_bidx;
   logic [DAT_W-1:0]  r_word;
   logic [TO_W-1:0]   r_idle;

   uart_rx_core #(
      .CLK_HZ (CLK_HZ),
      .BAUD   (BAUD)
   ) u_rx (
      .clock      (clock),
      .reset      (reset),
      .i_rx       (rx),
      .o_byte_vld (w_byte_vld),
      .o_byte     (w_byte),
      .o_frm_err  (w_frm_err)
   );

   assign w_timed   = (r_state == S_LEN0) || (r_state == S_LEN1) || (r_state == S_DATA);
   assign w_timeout = w_timed && (r_idle == TO_W'(TIMEOUT_CYC));
   assign w_len     = {w_byte, r_len[7:0]};
   assign w_word    = {w_byte, r_word[23:0]};

   // Inter-byte idle counter; only meaningful inside a frame body.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                      r_idle <= '0;
      else if (!w_timed || w_byte_vld) r_idle <= '0;
      else if (!w_timeout)             r_idle <= r_idle + TO_W'(1);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state    <= S_OFF;
         r_target   <= 1'b0;
         r_len      <= '0;
         r_widx     <= '0;
         r_bidx     <= '0;
         r_word     <= '0;
         upg_wen_o  <= 1'b0;
         upg_adr_o  <= '0;
         upg_dat_o  <= '0;
         upg_done_o <= 1'b0;
         busy       <= 1'b0;
         err        <= 1'b0;
      end else begin
         upg_wen_o <= 1'b0;
         case (r_state)
            S_OFF, S_DONE, S_ERR: begin
               if (start) begin
                  upg_done_o <= 1'b0;
                  if (w_frm_err) begin
                     r_state <= S_ERR;
                     err     <= 1'b1;
                  end else begin
                     r_state <= S_CMD;
                     busy    <= 1'b1;
                     err     <= 1'b0;
                  end
               end
            end
            S_CMD: begin
               if (w_frm_err) begin
                  r_state <= S_ERR;
                  busy    <= 1'b0;
                  err     <= 1'b1;
               end else if (w_byte_vld) begin
                  if (w_byte == CMD_IMEM || w_byte == CMD_DMEM) begin
                     r_target <= w_byte[0];
                     r_state  <= S_LEN0;
                  end else if (w_byte == CMD_END) begin
                     r_state    <= S_DONE;
                     busy       <= 1'b0;
                     upg_done_o <= 1'b1;
                  end else begin
                     r_state <= S_ERR;
                     busy    <= 1'b0;
                     err     <= 1'b1;
                  end
               end
            end
            S_LEN0: begin
               if (w_frm_err || w_timeout) begin
                  r_state <= S_ERR;
                  busy    <= 1'b0;
                  err     <= 1'b1;
               end else if (w_byte_vld) begin
                  r_len[7:0] <= w_byte;
                  r_state    <= S_LEN1;
               end
            end
            S_LEN1: begin
               if (w_frm_err || w_timeout) begin
                  r_state <= S_ERR;
                  busy    <= 1'b0;
                  err     <= 1'b1;
               end else if (w_byte_vld) begin
                  r_len <= w_len;
                  if (w_len == '0) begin
                     r_state <= S_CMD;
                  end else if (w_len > LEN_W'(MAX_WORDS)) begin
                     r_state <= S_ERR;
                     busy    <= 1'b0;
                     err     <= 1'b1;
                  end else begin
                     r_widx  <= '0;
                     r_bidx  <= '0;
                     r_state <= S_DATA;
                  end
               end
            end
            // Bytes arrive LSB first; the fourth byte completes and emits the word.
            S_DATA: begin
               if (w_frm_err || w_timeout) begin
                  r_state <= S_ERR;
                  busy    <= 1'b0;
                  err     <= 1'b1;
               end else if (w_byte_vld) begin
                  if (r_bidx == 2'd3) begin
                     upg_wen_o <= 1'b1;
                     upg_adr_o <= {r_target, r_widx};
                     upg_dat_o <= w_word;
                     r_widx    <= r_widx + WIDX_W'(1);
                     r_bidx    <= '0;
                     if ({2'b00, r_widx} == r_len - LEN_W'(1)) r_state <= S_CMD;
                  end else begin
                     r_word[{r_bidx, 3'b000} +: 8] <= w_byte;
                     r_bidx <= r_bidx + 2'd1;
                  end
               end
            end
            default: begin
               r_state <= S_OFF;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_upg_loader.sv
// Directed bench for upg_loader: drives a UART byte model and checks the write port.
module tb_upg_loader;

   localparam int unsigned CLK_HZ  = 10_000_000;
   localparam int unsigned BAUD    = 128_000;
   localparam int unsigned BIT_CYC = CLK_HZ / BAUD;
   localparam int unsigned TO_CYC  = 5000;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        rx;
   logic        upg_wen_o;
   logic [14:0] upg_adr_o;
   logic [31:0] upg_dat_o;
   logic        upg_done_o;
   logic        busy;
   logic        err;

   int          n_chk  = 0;
   int          n_pass = 0;
   int          base;
   logic [14:0] q_adr[$];
   logic [31:0] q_dat[$];
   logic [7:0]  seq[$];

   upg_loader #(
      .CLK_HZ      (CLK_HZ),
      .BAUD        (BAUD),
      .TIMEOUT_CYC (TO_CYC)
   ) dut (
      .clock      (clk),
      .reset      (rst_n),
      .start      (start),
      .rx         (rx),
      .upg_wen_o  (upg_wen_o),
      .upg_adr_o  (upg_adr_o),
      .upg_dat_o  (upg_dat_o),
      .upg_done_o (upg_done_o),
      .busy       (busy),
      .err        (err)
   );

   initial clk = 1'b0;
   always #50 clk = ~clk;

   // Record every write strobe seen between clock edges.
   always @(negedge clk) begin
      if (upg_wen_o) begin
         q_adr.push_back(upg_adr_o);
         q_dat.push_back(upg_dat_o);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #10;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic logic [31:0] stb_adr(input int i);
      if (i < q_adr.size()) return 32'(q_adr[i]);
      return 'x;
   endfunction

   function automatic logic [31:0] stb_dat(input int i);
      if (i < q_dat.size()) return q_dat[i];
      return 'x;
   endfunction

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      tick(BIT_CYC);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(BIT_CYC);
      end
      rx = stop_bit;
      tick(BIT_CYC);
      rx = 1'b1;
      tick(10);
   endtask

   task automatic send_seq(input logic [7:0] s[$]);
      foreach (s[i]) send_byte(s[i], 1'b1);
      tick(5);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(2);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      rx    = 1'b1;
      tick(5);
      chk("rst_wen",  32'(upg_wen_o),  32'd0);
      chk("rst_adr",  32'(upg_adr_o),  32'd0);
      chk("rst_dat",  upg_dat_o,       32'd0);
      chk("rst_done", 32'(upg_done_o), 32'd0);
      chk("rst_busy", 32'(busy),       32'd0);
      chk("rst_err",  32'(err),        32'd0);
      rst_n = 1'b1;
      tick(5);

      // Two imem words.
      pulse_start();
      chk("t1_busy", 32'(busy), 32'd1);
      seq = '{8'h00, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      send_seq(seq);
      chk("t1_nstb", 32'(q_adr.size()), 32'd2);
      chk("t1_adr0", stb_adr(0), 32'h0000);
      chk("t1_dat0", stb_dat(0), 32'h12345678);
      chk("t1_adr1", stb_adr(1), 32'h0001);
      chk("t1_dat1", stb_dat(1), 32'hDEADBEEF);
      chk("t1_busy_hold", 32'(busy), 32'd1);

      // One dmem word, then END.
      seq = '{8'h01, 8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hFF};
      send_seq(seq);
      chk("t2_nstb", 32'(q_adr.size()), 32'd3);
      chk("t2_adr",  stb_adr(2), 32'h4000);
      chk("t2_dat",  stb_dat(2), 32'h11223344);
      chk("t2_done", 32'(upg_done_o), 32'd1);
      chk("t2_busy", 32'(busy), 32'd0);
      chk("t2_err",  32'(err), 32'd0);

      // Illegal command, then recovery.
      pulse_start();
      chk("t3_done_clr", 32'(upg_done_o), 32'd0);
      chk("t3_busy", 32'(busy), 32'd1);
      seq = '{8'h07};
      send_seq(seq);
      chk("t3_err", 32'(err), 32'd1);
      chk("t3_busy_err", 32'(busy), 32'd0);
      chk("t3_nstb", 32'(q_adr.size()), 32'd3);
      pulse_start();
      chk("t3_err_clr", 32'(err), 32'd0);
      seq = '{8'hFF};
      send_seq(seq);
      chk("t3_done", 32'(upg_done_o), 32'd1);
      chk("t3_err_end", 32'(err), 32'd0);

      // Inter-byte timeout inside DATA.
      pulse_start();
      seq = '{8'h00, 8'h01, 8'h00, 8'hAA};
      send_seq(seq);
      tick(4000);
      chk("t4_no_early_err", 32'(err), 32'd0);
      tick(1500);
      chk("t4_err", 32'(err), 32'd1);
      chk("t4_busy", 32'(busy), 32'd0);
      chk("t4_nstb", 32'(q_adr.size()), 32'd3);

      // Bad stop bit in DATA, then a short glitch on an idle line.
      pulse_start();
      seq = '{8'h00, 8'h01, 8'h00};
      send_seq(seq);
      send_byte(8'hAA, 1'b0);
      tick(5);
      chk("t5_frm_err", 32'(err), 32'd1);
      chk("t5_nstb", 32'(q_adr.size()), 32'd3);
      pulse_start();
      chk("t5_err_clr", 32'(err), 32'd0);
      rx = 1'b0;
      tick(23);
      rx = 1'b1;
      tick(300);
      chk("t5_glitch_err",  32'(err), 32'd0);
      chk("t5_glitch_busy", 32'(busy), 32'd1);
      chk("t5_glitch_done", 32'(upg_done_o), 32'd0);
      seq = '{8'hFF};
      send_seq(seq);
      chk("t5_done", 32'(upg_done_o), 32'd1);

      // Asynchronous reset in the middle of a word.
      pulse_start();
      seq = '{8'h00, 8'h02, 8'h00, 8'h78, 8'h56};
      send_seq(seq);
      chk("t6_busy_pre", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_wen",  32'(upg_wen_o),  32'd0);
      chk("t6_adr",  32'(upg_adr_o),  32'd0);
      chk("t6_dat",  upg_dat_o,       32'd0);
      chk("t6_done", 32'(upg_done_o), 32'd0);
      chk("t6_busy", 32'(busy),       32'd0);
      chk("t6_err",  32'(err),        32'd0);
      tick(3);
      chk("t6_nstb_rst", 32'(q_adr.size()), 32'd3);
      rst_n = 1'b1;
      tick(3);
      base = q_adr.size();
      pulse_start();
      seq = '{8'h00, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      send_seq(seq);
      chk("t6_nstb", 32'(q_adr.size()), 32'(base + 2));
      chk("t6_adr0", stb_adr(base),     32'h0000);
      chk("t6_dat0", stb_dat(base),     32'h12345678);
      chk("t6_adr1", stb_adr(base + 1), 32'h0001);
      chk("t6_dat1", stb_dat(base + 1), 32'hDEADBEEF);
      chk("t6_err_end", 32'(err), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
